// File: rtl/tia_horizontal_scheduler_pkg.sv
// Shared constants and helpers for the TIA horizontal scheduler.
package tia_horizontal_scheduler_pkg;
`include "tia_timing.vh"

    localparam int DEF_LINE_CLKS    = `TIA_LINE_CLKS;
    localparam int DEF_HBLANK_END   = `TIA_HBLANK_END;
    localparam int DEF_HMOVE_EXT    = `TIA_HMOVE_EXT;
    localparam int DEF_HSYNC_START  = `TIA_HSYNC_START;
    localparam int DEF_HSYNC_END    = `TIA_HSYNC_END;
    localparam int DEF_CBURST_START = `TIA_CBURST_START;
    localparam int DEF_CBURST_END   = `TIA_CBURST_END;
    localparam int DEF_RSYNC_LOAD   = `TIA_RSYNC_LOAD;

    // Half-open window test on the colour-clock counter.
    function automatic logic in_window(
        input logic [7:0] cc,
        input logic [7:0] lo,
        input logic [7:0] hi
    );
        return (cc >= lo) && (cc < hi);
    endfunction

endpackage

// File: rtl/tia_hline_decode.sv
// Combinational line-timing decode from the colour-clock position.
module tia_hline_decode
    import tia_horizontal_scheduler_pkg::*;
#(
    parameter int HBLANK_END   = DEF_HBLANK_END,
    parameter int HMOVE_EXT    = DEF_HMOVE_EXT,
    parameter int HSYNC_START  = DEF_HSYNC_START,
    parameter int HSYNC_END    = DEF_HSYNC_END,
    parameter int CBURST_START = DEF_CBURST_START,
    parameter int CBURST_END   = DEF_CBURST_END
) (
    input  logic [7:0] cc,
    input  logic       hmove_line,
    output logic       hblank,
    output logic       hsync,
    output logic       cburst,
    output logic       line_start
);

    localparam logic [7:0] BLANK_END = 8'(HBLANK_END);
    localparam logic [7:0] EXT_END   = 8'(HBLANK_END + HMOVE_EXT);

    always_comb begin
        hblank     = (cc < BLANK_END) || (hmove_line && (cc < EXT_END));
        hsync      = in_window(cc, 8'(HSYNC_START), 8'(HSYNC_END));
        cburst     = in_window(cc, 8'(CBURST_START), 8'(CBURST_END));
        line_start = (cc == 8'd0);
    end

endmodule

// File: rtl/tia_timing.vh
// Line timing constants for the TIA horizontal scheduler, in colour clocks.
`ifndef TIA_TIMING_VH
`define TIA_TIMING_VH
`define TIA_LINE_CLKS    228
`define TIA_HBLANK_END   68
`define TIA_HMOVE_EXT    8
`define TIA_HSYNC_START  16
`define TIA_HSYNC_END    32
`define TIA_CBURST_START 36
`define TIA_CBURST_END   48
`define TIA_RSYNC_LOAD   224
`endif

// File: rtl/tia_horizontal_scheduler.sv
// TIA scan-line sequencer: colour-clock counter, phase enables, line decodes
// and the RSYNC/WSYNC/HMOVE strobe handling.
module tia_horizontal_scheduler
    import tia_horizontal_scheduler_pkg::*;
#(
    parameter int LINE_CLKS    = DEF_LINE_CLKS,
    parameter int HBLANK_END   = DEF_HBLANK_END,
    parameter int HMOVE_EXT    = DEF_HMOVE_EXT,
    parameter int HSYNC_START  = DEF_HSYNC_START,
    parameter int HSYNC_END    = DEF_HSYNC_END,
    parameter int CBURST_START = DEF_CBURST_START,
    parameter int CBURST_END   = DEF_CBURST_END,
    parameter int RSYNC_LOAD   = DEF_RSYNC_LOAD
) (
    input  logic       clk,
    input  logic       r,
    input  logic       rsync_strobe,
    input  logic       wsync_strobe,
    input  logic       hmove_strobe,
    output logic       phi1_en,
    output logic       phi2_en,
    output logic [5:0] hcount,
    output logic       line_start,
    output logic       hblank,
    output logic       hsync,
    output logic       cburst,
    output logic       hmove_line,
    output logic       rdy
);

    localparam logic [7:0] LAST_CC = 8'(LINE_CLKS - 1);
    localparam logic [7:0] LOAD_CC = 8'(RSYNC_LOAD);

    logic [7:0] cc;
    logic [7:0] cc_nxt;
    logic       wrap;
    logic       hmove_pend;
    logic       wsync_pend;

    always_comb begin
        cc_nxt = cc + 8'd1;
        if (rsync_strobe) begin
            cc_nxt = LOAD_CC;
        end else if (cc == LAST_CC) begin
            cc_nxt = 8'd0;
        end
        wrap = (cc_nxt == 8'd0);
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            cc         <= 8'd0;
            hmove_pend <= 1'b0;
            hmove_line <= 1'b0;
            wsync_pend <= 1'b0;
        end else begin
            cc <= cc_nxt;
            // A strobe on the wrap edge belongs to the line now starting.
            if (wrap) begin
                hmove_line <= hmove_pend | hmove_strobe;
                hmove_pend <= 1'b0;
            end else if (hmove_strobe) begin
                hmove_pend <= 1'b1;
            end
            // Set beats clear, so a strobe on the wrap stalls a full line.
            if (wsync_strobe) begin
                wsync_pend <= 1'b1;
            end else if (wrap) begin
                wsync_pend <= 1'b0;
            end
        end
    end

    assign phi1_en = (cc[1:0] == 2'd0);
    assign phi2_en = (cc[1:0] == 2'd2);
    assign hcount  = cc[7:2];
    assign rdy     = ~wsync_pend;

    tia_hline_decode #(
        .HBLANK_END   (HBLANK_END),
        .HMOVE_EXT    (HMOVE_EXT),
        .HSYNC_START  (HSYNC_START),
        .HSYNC_END    (HSYNC_END),
        .CBURST_START (CBURST_START),
        .CBURST_END   (CBURST_END)
    ) u_decode (
        .cc         (cc),
        .hmove_line (hmove_line),
        .hblank     (hblank),
        .hsync      (hsync),
        .cburst     (cburst),
        .line_start (line_start)
    );

endmodule
